// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises a 10-bit {opcode, payload} frame on MOSI under SS_n, and captures an
// 8-bit MISO reply for read-data frames (opcode 2'b11). Optional abort input: SPI_MASTER_ABORT_EN.
module spi_master_ctrl #(
    parameter int TURN_CYC = 3,
    parameter int GAP_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef SPI_MASTER_ABORT_EN
    input  logic       abort,
`endif
    input  logic       start,
    input  logic [9:0] frame_in,
    input  logic       MISO,
    output logic       MOSI,
    output logic       SS_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SEL   = 3'd1;
    localparam logic [2:0] CMD   = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;
    localparam logic [2:0] WAIT  = 3'd5;
    localparam logic [2:0] RECV  = 3'd6;
    localparam logic [2:0] GAP   = 3'd7;

    logic [2:0] state;
    logic [3:0] cnt;
    logic [9:0] tx_shift;
    logic [7:0] rx_shift;
    logic       rd_frame;
    logic       abort_hit;

`ifdef SPI_MASTER_ABORT_EN
    assign abort_hit = abort && (state != IDLE) && (state != GAP);
`else
    assign abort_hit = 1'b0;
`endif

    // Outputs decode straight from registered state, so async reset takes effect immediately.
    assign SS_n = (state == IDLE) || (state == GAP);
    assign MOSI = ((state == CMD) || (state == SHIFT)) ? tx_shift[9] : 1'b0;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            tx_shift <= 10'd0;
            rx_shift <= 8'd0;
            rd_frame <= 1'b0;
            rd_data  <= 8'd0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            if (abort_hit) begin
                state <= GAP;
                cnt   <= 4'(GAP_CYC - 1);
                done  <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        tx_shift <= frame_in;
                        rd_frame <= (frame_in[9:8] == 2'b11);
                        state    <= SEL;
                    end
                    SEL: state <= CMD;
                    // CMD shows frame[9] without shifting; SHIFT then replays it as the first data bit.
                    CMD: begin
                        state <= SHIFT;
                        cnt   <= 4'd9;
                    end
                    SHIFT: begin
                        tx_shift <= {tx_shift[8:0], 1'b0};
                        if (cnt == 4'd0) begin
                            if (rd_frame) begin
                                state <= WAIT;
                                cnt   <= 4'(TURN_CYC - 1);
                            end else begin
                                state <= HOLD;
                            end
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    HOLD: begin
                        state <= GAP;
                        cnt   <= 4'(GAP_CYC - 1);
                        done  <= 1'b1;
                    end
                    WAIT: begin
                        if (cnt == 4'd0) begin
                            state <= RECV;
                            cnt   <= 4'd7;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    RECV: begin
                        rx_shift <= {rx_shift[6:0], MISO};
                        if (cnt == 4'd0) begin
                            rd_data  <= {rx_shift[6:0], MISO};
                            rd_valid <= 1'b1;
                            done     <= 1'b1;
                            state    <= GAP;
                            cnt      <= 4'(GAP_CYC - 1);
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    GAP: begin
                        if (cnt == 4'd0) state <= IDLE;
                        else             cnt   <= cnt - 4'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: vector table, randomized frames against a cycle-level frame model,
// and hand sequences for reset, back-to-back, start-at-gap-end and (with SPI_MASTER_ABORT_EN) abort.
module tb_spi_master_ctrl;
    localparam int TURN = 3;
    localparam int GAPC = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] frame_in = 10'd0;
    logic       MISO = 1'b0;
    logic       MOSI, SS_n, busy, done, rd_valid;
    logic [7:0] rd_data;
`ifdef SPI_MASTER_ABORT_EN
    logic       abort = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] ref_rd = 8'd0;

    spi_master_ctrl #(.TURN_CYC(TURN), .GAP_CYC(GAPC)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef SPI_MASTER_ABORT_EN
        .abort(abort),
`endif
        .start(start), .frame_in(frame_in), .MISO(MISO), .MOSI(MOSI), .SS_n(SS_n),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] frame;
        logic [7:0] miso;
        int         exp_len;
        logic [7:0] exp_rd;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected MOSI on the k-th SS_n-low cycle (0 = select cycle).
    function automatic logic exp_mosi(input logic [9:0] f, input int k);
        if (k == 1) return f[9];
        if (k >= 2 && k <= 11) return f[11 - k];
        return 1'b0;
    endfunction

    task automatic do_frame(input logic [9:0] f, input logic [7:0] mb, input int exp_len,
                            input logic [7:0] exp_rd);
        bit rd;
        int k, errs, pulses;
        bit fin;
        rd = (f[9:8] == 2'b11);
        k = 0; errs = 0; pulses = 0; fin = 0;
        @(negedge clk);
        start = 1'b1; frame_in = f;
        @(posedge clk); #1;
        start = 1'b0; frame_in = 10'($urandom);
        for (int c = 0; c < 80 && !fin; c++) begin
            @(negedge clk);
            if (c == 0) check("busy_after_start", busy, 1);
            if (!SS_n) begin
                if (MOSI !== exp_mosi(f, k)) errs++;
                if (done || rd_valid) pulses++;
                if (rd && k >= 12 + TURN && k < 20 + TURN) MISO = mb[7 - (k - 12 - TURN)];
                else MISO = 1'($urandom);
                k++;
            end else if (k > 0) begin
                fin = 1;
                check("mosi_seq_errs", errs, 0);
                check("ss_low_len", k, exp_len);
                check("spurious_pulse", pulses, 0);
                check("done_at_rise", done, 1);
                check("rd_valid_at_rise", rd_valid, rd);
                check("rd_data", rd_data, exp_rd);
                check("busy_in_gap", busy, 1);
            end
        end
        if (!fin) check("frame_timeout", 0, 1);
        repeat (GAPC) @(negedge clk);
        check("busy_after_gap", busy, 0);
        check("done_after_gap", done, 0);
        check("ss_after_gap", SS_n, 1);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{10'h0_A5, 8'h00, 13, 8'h00};
        tbl[1] = '{10'h1_3C, 8'hFF, 13, 8'h00};
        tbl[2] = '{10'h3_00, 8'hC3, 20 + TURN, 8'hC3};
        tbl[3] = '{10'h2_7E, 8'h00, 13, 8'hC3};
        tbl[4] = '{10'h3_FF, 8'h5A, 20 + TURN, 8'h5A};
        tbl[5] = '{10'h0_00, 8'hAA, 13, 8'h5A};

        // Reset state
        #12;
        check("rst_ss_n", SS_n, 1);
        check("rst_mosi", MOSI, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        @(negedge clk); rst_n = 1'b1;

        foreach (tbl[i]) do_frame(tbl[i].frame, tbl[i].miso, tbl[i].exp_len, tbl[i].exp_rd);
        ref_rd = 8'h5A;

        for (int i = 0; i < 20; i++) begin
            logic [9:0] f;
            logic [7:0] mb;
            f  = 10'($urandom);
            mb = 8'($urandom);
            if (f[9:8] == 2'b11) ref_rd = mb;
            do_frame(f, mb, (f[9:8] == 2'b11) ? 20 + TURN : 13, ref_rd);
        end

        // Back-to-back with start held high: next select GAP+1 cycles after SS_n rise
        begin
            int t, gap;
            bit seen;
            t = 0; seen = 0; gap = 0;
            @(negedge clk); start = 1'b1; frame_in = 10'h0_A5;
            for (int c = 0; c < 60 && !seen; c++) begin
                @(negedge clk);
                if (!SS_n && t == 1) begin gap = c; seen = 1; end
                else if (SS_n && t == 0 && c > 0) begin t = 1; gap = c; end
            end
            if (seen) begin
                int rise;
                rise = 0;
                // gap held rise index until select observed; recompute distance
                check("b2b_seen", seen, 1);
            end else check("b2b_timeout", 0, 1);
            start = 1'b0;
            for (int c = 0; c < 40 && busy; c++) @(negedge clk);
            check("b2b_idle", busy, 0);
        end

        // Precise back-to-back distance measurement
        begin
            int rise_c, sel_c;
            rise_c = -1; sel_c = -1;
            @(negedge clk); start = 1'b1; frame_in = 10'h1_3C;
            for (int c = 0; c < 60 && sel_c < 0; c++) begin
                @(negedge clk);
                if (rise_c < 0 && SS_n && c > 1) rise_c = c;
                else if (rise_c >= 0 && !SS_n) sel_c = c;
            end
            start = 1'b0;
            check("b2b_sel_distance", sel_c - rise_c, GAPC + 1);
            for (int c = 0; c < 40 && busy; c++) @(negedge clk);
        end

        // Start pulsed only in the last GAP cycle is not accepted
        begin
            int lows;
            bit rose;
            lows = 0; rose = 0;
            @(negedge clk); start = 1'b1; frame_in = 10'h0_11;
            @(posedge clk); #1 start = 1'b0;
            for (int c = 0; c < 40 && !rose; c++) begin
                @(negedge clk);
                if (SS_n && c > 1) rose = 1;
            end
            repeat (GAPC - 1) @(negedge clk);
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (!SS_n) lows++;
            end
            check("start_at_gap_end_ignored", lows, 0);
        end

        // Async reset mid-SHIFT
        begin
            @(negedge clk); start = 1'b1; frame_in = 10'h3_FF;
            @(posedge clk); #1 start = 1'b0;
            repeat (6) @(negedge clk);
            check("pre_reset_ss_low", SS_n, 0);
            #2 rst_n = 1'b0;
            #1;
            check("mid_rst_ss_n", SS_n, 1);
            check("mid_rst_mosi", MOSI, 0);
            check("mid_rst_busy", busy, 0);
            check("mid_rst_rd_data", rd_data, 0);
            @(negedge clk); rst_n = 1'b1;
            ref_rd = 8'h00;
            do_frame(10'h0_A5, 8'h00, 13, ref_rd);
        end

`ifdef SPI_MASTER_ABORT_EN
        begin
            @(negedge clk); start = 1'b1; frame_in = 10'h3_00;
            @(posedge clk); #1 start = 1'b0;
            // SS_n-low index 7 carries frame bit 4
            repeat (8) @(negedge clk);
            abort = 1'b1;
            @(posedge clk); #1 abort = 1'b0;
            @(negedge clk);
            check("abort_ss_n", SS_n, 1);
            check("abort_done", done, 1);
            check("abort_rd_valid", rd_valid, 0);
            check("abort_rd_data", rd_data, ref_rd);
            repeat (GAPC) @(negedge clk);
            check("abort_idle", busy, 0);
            do_frame(10'h3_12, 8'h96, 20 + TURN, 8'h96);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
